// File: rtl/cpu_types_pkg.sv
// Shared CPU types: bus word and RAM handshake status.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/my_types_pkg.sv
// Memory-bus arbiter types and requester index map.
package my_types_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_ACCESS
    } arb_state_t;

    // Even index = dcache, odd index = icache; core = index / 2.
    localparam int unsigned REQ_C0_D = 0;
    localparam int unsigned REQ_C0_I = 1;
    localparam int unsigned REQ_C1_D = 2;
    localparam int unsigned REQ_C1_I = 3;

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Winner selection: dcache class beats icache class, round-robin between
// cores within a class starting after last_core.
module mem_arb_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NCORE = NREQ / 2,
    parameter int unsigned CW    = (NCORE > 1) ? $clog2(NCORE) : 1
) (
    input  logic [NREQ-1:0] active,
    input  logic [NREQ-1:0] exclude,
    input  logic [CW-1:0]   last_core,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    logic [NREQ-1:0] cand;

    // First candidate in class order, then core order rotated past last_core
    always_comb begin
        cand   = active & ~exclude;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned cls = 0; cls < 2; cls++) begin
            for (int unsigned k = 1; k <= NCORE; k++) begin
                if (!valid && cand[2 * ((32'(last_core) + k) % NCORE) + cls]) begin
                    winner[2 * ((32'(last_core) + k) % NCORE) + cls] = 1'b1;
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shared RAM port arbiter for the four cache requesters of the dual-core system.
module mem_bus_arbiter
    import cpu_types_pkg::*;
    import my_types_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic      [NREQ-1:0]  req_ren,
    input  logic      [NREQ-1:0]  req_wen,
    input  logic      [NREQ-1:0]  req_hold,
    input  word_t     [NREQ-1:0]  req_addr,
    input  word_t     [NREQ-1:0]  req_store,
    output logic      [NREQ-1:0]  req_wait,
    output word_t                 req_load,
    output logic      [NREQ-1:0]  grant,
    output logic                  ramREN,
    output logic                  ramWEN,
    output word_t                 ramaddr,
    output word_t                 ramstore,
    input  word_t                 ramload,
    input  ramstate_t             ramstate
);

    localparam int unsigned NCORE = NREQ / 2;
    localparam int unsigned CW    = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_t      state;
    logic [HW-1:0]   hold_cnt;
    logic [CW-1:0]   last_core;

    logic [NREQ-1:0] active;
    logic [IW-1:0]   owner_idx;
    logic [CW-1:0]   owner_core;
    logic            owner_active;
    logic            done;
    logic            hold_more;
    logic [CW-1:0]   pick_last;
    logic [NREQ-1:0] pick_winner;
    logic            pick_valid;

    assign active       = req_ren | req_wen;
    assign owner_core   = CW'(owner_idx >> 1);
    assign owner_active = |(grant & active);
    assign done         = (state == ARB_ACCESS) && (ramstate == ACCESS);
    assign hold_more    = req_hold[owner_idx] && ((32'(hold_cnt) + 32'd1) < MAX_HOLD);
    assign req_wait     = active & ~(grant & {NREQ{done}});
    assign req_load     = ramload;

    // On release the round-robin must already see the outgoing owner's core,
    // so the picker gets it directly rather than the not-yet-updated register.
    // In idle grant is zero, so excluding grant excludes nobody.
    assign pick_last = (state == ARB_ACCESS) ? owner_core : last_core;

    mem_arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .active    (active),
        .exclude   (grant),
        .last_core (pick_last),
        .winner    (pick_winner),
        .valid     (pick_valid)
    );

    // Encode the one-hot grant into an owner index
    always_comb begin
        owner_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) owner_idx = IW'(i);
        end
    end

    // Steer the owner's request onto the RAM port; quiet when idle
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state == ARB_ACCESS) begin
            ramWEN   = req_wen[owner_idx];
            ramREN   = req_ren[owner_idx] & ~req_wen[owner_idx];
            ramaddr  = req_addr[owner_idx];
            ramstore = req_store[owner_idx];
        end
    end

    // Arbitration FSM: grant, hold counter and round-robin pointer
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            hold_cnt  <= '0;
            last_core <= CW'(1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant    <= pick_winner;
                        hold_cnt <= '0;
                        state    <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (!owner_active) begin
                        grant    <= '0;
                        hold_cnt <= '0;
                        state    <= ARB_IDLE;
                    end else if (done) begin
                        if (hold_more) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end else begin
                            last_core <= owner_core;
                            hold_cnt  <= '0;
                            if (pick_valid) begin
                                grant <= pick_winner;
                            end else begin
                                grant <= '0;
                                state <= ARB_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    grant    <= '0;
                    hold_cnt <= '0;
                    state    <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random traffic.
module tb_mem_bus_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic [3:0]      req_ren, req_wen, req_hold, req_wait, grant;
    word_t [3:0]     req_addr, req_store;
    word_t           req_load, ramaddr, ramstore, ramload;
    logic            ramREN, ramWEN;
    ramstate_t       ramstate;

    always #5 CLK = ~CLK;

    mem_bus_arbiter #(
        .NREQ     (NREQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_ren   (req_ren),
        .req_wen   (req_wen),
        .req_hold  (req_hold),
        .req_addr  (req_addr),
        .req_store (req_store),
        .req_wait  (req_wait),
        .req_load  (req_load),
        .grant     (grant),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: owner as an integer (-1 = nobody), hold count, last core.
    int m_owner, m_hcnt, m_last;
    logic [3:0] m_last_wait;

    // Lowest score wins: icache costs 10, sharing the last core costs 1.
    function automatic int m_pick(input logic [3:0] act, input int excl, input int lastc);
        int best = -1;
        int best_score = 100;
        for (int i = 0; i < 4; i++) begin
            if (act[i] && i != excl) begin
                int score;
                score = (i % 2) * 10 + (((i / 2) == lastc) ? 1 : 0);
                if (score < best_score) begin
                    best_score = score;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    logic [3:0] snap_grant, snap_wait;
    logic       snap_ren;
    word_t      snap_addr, snap_load, drv_load;

    task automatic step(input logic [3:0] ren, input logic [3:0] wen, input logic [3:0] hold,
                        input ramstate_t rs, input logic rst);
        logic [3:0] act, e_grant, e_wait;
        logic       done, e_ren, e_wen;
        word_t      e_addr, e_store;
        int         w;
        req_ren  = ren;
        req_wen  = wen;
        req_hold = hold;
        ramstate = rs;
        RST      = rst;
        ramload  = $urandom;
        drv_load = ramload;
        #4;
        act     = ren | wen;
        done    = (m_owner >= 0) && (rs == ACCESS);
        e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_addr  = '0;
        e_store = '0;
        if (m_owner >= 0) begin
            e_wen   = wen[m_owner];
            e_ren   = ren[m_owner] & ~wen[m_owner];
            e_addr  = req_addr[m_owner];
            e_store = req_store[m_owner];
        end
        for (int i = 0; i < 4; i++) e_wait[i] = act[i] && !(m_owner == i && done);
        check_eq("grant",    32'(grant),    32'(e_grant));
        check_eq("req_wait", 32'(req_wait), 32'(e_wait));
        check_eq("ram_en",   32'({ramREN, ramWEN}), 32'({e_ren, e_wen}));
        check_eq("ramaddr",  ramaddr,  e_addr);
        check_eq("ramstore", ramstore, e_store);
        check_eq("req_load", req_load, drv_load);
        snap_grant  = grant;
        snap_wait   = req_wait;
        snap_ren    = ramREN;
        snap_addr   = ramaddr;
        snap_load   = req_load;
        m_last_wait = e_wait;
        if (rst) begin
            m_owner = -1; m_hcnt = 0; m_last = 1;
        end else if (m_owner < 0) begin
            w = m_pick(act, -1, m_last);
            if (w >= 0) begin m_owner = w; m_hcnt = 0; end
        end else if (!act[m_owner]) begin
            m_owner = -1; m_hcnt = 0;
        end else if (done) begin
            if (hold[m_owner] && m_hcnt < MAX_HOLD - 1) begin
                m_hcnt++;
            end else begin
                m_last  = m_owner / 2;
                m_owner = m_pick(act, m_owner, m_last);
                m_hcnt  = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] alt_exp [4];
    logic [3:0] r_ren, r_wen, r_hold, r_act;
    ramstate_t  r_rs;
    int         r;

    initial begin
        RST = 1'b1; req_ren = '0; req_wen = '0; req_hold = '0;
        ramstate = FREE; ramload = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i]  = 32'h1000 * (i + 1);
            req_store[i] = 32'hA000_0000 + i;
        end
        req_addr[1] = 32'h100;
        @(posedge CLK); #1;
        m_owner = -1; m_hcnt = 0; m_last = 1; m_last_wait = '0;

        // Reset state, and wait follows active while in reset
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b0);
        check_eq("rst_grant", 32'(snap_grant), 32'h0);
        step(4'b0011, 4'b0000, 4'b0000, FREE, 1'b1);
        check_eq("rst_wait", 32'(snap_wait), 32'h3);

        // Core0 icache read at 0x100, two BUSY cycles then ACCESS
        step(4'b0010, 4'b0000, 4'b0000, BUSY, 1'b0);
        step(4'b0010, 4'b0000, 4'b0000, BUSY, 1'b0);
        check_eq("ic_grant", 32'(snap_grant), 32'h2);
        check_eq("ic_addr",  snap_addr, 32'h100);
        check_eq("ic_ren",   32'(snap_ren), 32'h1);
        check_eq("ic_wait1", 32'(snap_wait[1]), 32'h1);
        step(4'b0010, 4'b0000, 4'b0000, BUSY, 1'b0);
        check_eq("ic_wait2", 32'(snap_wait[1]), 32'h1);
        step(4'b0010, 4'b0000, 4'b0000, ACCESS, 1'b0);
        check_eq("ic_wait3", 32'(snap_wait[1]), 32'h0);
        check_eq("ic_load",  snap_load, drv_load);
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b0);

        // Class priority and bubble-free handoff
        step(4'b0110, 4'b0000, 4'b0000, FREE, 1'b0);
        step(4'b0110, 4'b0000, 4'b0000, ACCESS, 1'b0);
        check_eq("cls_first", 32'(snap_grant), 32'h4);
        step(4'b0010, 4'b0000, 4'b0000, ACCESS, 1'b0);
        check_eq("cls_handoff", 32'(snap_grant), 32'h2);
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b0);
        check_eq("cls_idle", 32'(snap_grant), 32'h0);

        // Round-robin between the two dcaches
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b1);
        step(4'b0101, 4'b0000, 4'b0000, ACCESS, 1'b0);
        alt_exp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        for (int i = 0; i < 4; i++) begin
            step(4'b0101, 4'b0000, 4'b0000, ACCESS, 1'b0);
            check_eq("rr_alt", 32'(snap_grant), 32'(alt_exp[i]));
        end
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b0);

        // Hold limit: core1 dcache chains two accesses, then core0 dcache
        step(4'b0100, 4'b0000, 4'b0100, FREE, 1'b0);
        step(4'b0101, 4'b0000, 4'b0100, ACCESS, 1'b0);
        check_eq("hold_1", 32'(snap_grant), 32'h4);
        step(4'b0101, 4'b0000, 4'b0100, ACCESS, 1'b0);
        check_eq("hold_2", 32'(snap_grant), 32'h4);
        step(4'b0101, 4'b0000, 4'b0100, ACCESS, 1'b0);
        check_eq("hold_rel", 32'(snap_grant), 32'h1);
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b0);

        // Withdrawal mid-BUSY releases without moving the round-robin pointer
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b1);
        step(4'b0001, 4'b0000, 4'b0000, BUSY, 1'b0);
        step(4'b0001, 4'b0000, 4'b0000, BUSY, 1'b0);
        check_eq("wd_grant", 32'(snap_grant), 32'h1);
        step(4'b0000, 4'b0000, 4'b0000, BUSY, 1'b0);
        check_eq("wd_ren_drop", 32'(snap_ren), 32'h0);
        step(4'b0101, 4'b0000, 4'b0000, FREE, 1'b0);
        check_eq("wd_idle", 32'(snap_grant), 32'h0);
        step(4'b0101, 4'b0000, 4'b0000, ACCESS, 1'b0);
        check_eq("wd_last", 32'(snap_grant), 32'h1);
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b0);

        // Reset during an access
        step(4'b0100, 4'b0000, 4'b0000, BUSY, 1'b0);
        step(4'b0100, 4'b0000, 4'b0000, BUSY, 1'b0);
        check_eq("rm_grant", 32'(snap_grant), 32'h4);
        step(4'b0100, 4'b0000, 4'b0000, BUSY, 1'b1);
        step(4'b0101, 4'b0000, 4'b0000, BUSY, 1'b0);
        check_eq("rm_grant0", 32'(snap_grant), 32'h0);
        check_eq("rm_ren0",   32'(snap_ren), 32'h0);
        check_eq("rm_addr0",  snap_addr, 32'h0);
        step(4'b0101, 4'b0000, 4'b0000, ACCESS, 1'b0);
        check_eq("rm_core0", 32'(snap_grant), 32'h1);
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, FREE, 1'b0);

        // Random traffic against the model
        r_ren = '0; r_wen = '0; r_hold = '0;
        for (int c = 0; c < 3000; c++) begin
            r_act = r_ren | r_wen;
            for (int i = 0; i < 4; i++) begin
                logic start;
                start = 1'b0;
                if (r_act[i] && !m_last_wait[i]) begin
                    if ($urandom % 2 == 0) start = 1'b1;
                    else begin r_ren[i] = 1'b0; r_wen[i] = 1'b0; end
                end else if (r_act[i]) begin
                    if ($urandom % 40 == 0) begin r_ren[i] = 1'b0; r_wen[i] = 1'b0; end
                end else if ($urandom % 3 == 0) begin
                    start = 1'b1;
                end
                if (start) begin
                    r = int'($urandom % 4);
                    r_wen[i]     = (r <= 1);
                    r_ren[i]     = (r >= 1);
                    r_hold[i]    = ($urandom % 3 == 0);
                    req_addr[i]  = $urandom;
                    req_store[i] = $urandom;
                end
            end
            r = int'($urandom % 10);
            r_rs = (r < 4) ? ACCESS : (r < 8) ? BUSY : (r == 8) ? FREE : ERROR;
            step(r_ren, r_wen, r_hold, r_rs, ($urandom % 200 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single shared RAM port among the four cache requesters of the dual-core system: core0 dcache, core0 icache, core1 dcache, core1 icache. It applies fixed class priority (dcache over icache) and round-robin between cores. It supports a bounded grant lock so a cache FSM can complete multi-word block transfers without interruption. Its per-requester wait outputs are the stall sources that the hazard/forwarding logic consumes as ihit/dhit.

## Interface
Parameters:
- NREQ, 4: requester count. Index 0 = core0 dcache, 1 = core0 icache, 2 = core1 dcache, 3 = core1 icache; even index = dcache.
- MAX_HOLD, 2: maximum consecutive accesses one requester may chain using req_hold.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - CLK, in, 1: clock.
  - RST, in, 1: synchronous, active-high reset.
- Requester side:
  - req_ren, in, NREQ: read request per requester.
  - req_wen, in, NREQ: write request per requester.
  - req_hold, in, NREQ: keep grant after the current access completes.
  - req_addr, in, NREQ x word_t: access address.
  - req_store, in, NREQ x word_t: write data.
  - req_wait, out, NREQ: 1 = requester must stall.
  - req_load, out, word_t: read data, broadcast to all requesters.
  - grant, out, NREQ: one-hot, the current owner; all zero when idle.
- RAM side:
  - ramREN, out, 1: RAM read enable.
  - ramWEN, out, 1: RAM write enable.
  - ramaddr, out, word_t: RAM address.
  - ramstore, out, word_t: RAM write data.
  - ramload, in, word_t: RAM read data.
  - ramstate, in, ramstate_t: RAM status (FREE/BUSY/ACCESS/ERROR).

## Operation
- active[i] = req_ren[i] | req_wen[i].
- If req_ren and req_wen are both set, the access is treated as a write.
- States:
  - ARB_IDLE: no owner.
  - ARB_ACCESS: owner g drives the RAM.
- RAM outputs in ARB_ACCESS:
  - ramaddr = req_addr[g], ramstore = req_store[g].
  - ramWEN = req_wen[g]; ramREN = req_ren[g] & ~req_wen[g].
- RAM outputs in ARB_IDLE: all RAM outputs are 0.
- done = ARB_ACCESS & ramstate==ACCESS.
- req_wait[i] = active[i] & ~(grant[i] & done).
- req_load = ramload, combinational pass-through.
- BUSY, FREE and ERROR keep the owner waiting with no timeout. ERROR is not reported.
- Winner selection (mem_arb_pick):
  - Active dcache requesters beat icache requesters.
  - Within a class, the core != last_core wins.
  - If only one core requests in that class, it wins.
- Transitions at the clock edge:
  - ARB_IDLE with any active requester: pick a winner, load grant, go to ARB_ACCESS, hold_cnt=0.
  - ARB_ACCESS with done, req_hold[g]=1 and hold_cnt<MAX_HOLD-1: keep g, hold_cnt++.
  - ARB_ACCESS with done, otherwise (release):
    - last_core = core(g).
    - Pick among active requesters excluding g.
    - If a winner exists, grant it directly and reset hold_cnt (no idle bubble); else go to ARB_IDLE.
  - ARB_ACCESS with owner inactive (request withdrawn, e.g. pipeline flush): release without updating last_core, go to ARB_IDLE. No completion is signalled.
  - ARB_ACCESS otherwise: hold.
- Reset values: state ARB_IDLE, grant 0, hold_cnt 0, last_core 1 (core0 wins the first tie). All RAM outputs are 0. req_wait follows active.
- Reset asserted mid-access: the access is abandoned and the state above is loaded at the edge.

## Timing
- Arbitration latency: request first seen in IDLE at cycle n; RAM is driven from cycle n+1.
- A RAM ACCESS in cycle n+1 gives req_wait low and valid req_load in n+1 (zero-cycle completion path).
- Handoff: the next owner drives the RAM in the cycle after done, with no bubble.
- grant, state and hold_cnt are registered. RAM outputs, req_wait and req_load are combinational from registered grant and from inputs.
- No combinational path from req_* to grant.

## Structure
- cpu_types_pkg (existing): word_t, ramstate_t.
- my_types_pkg additions:
  - arb_state_t {ARB_IDLE, ARB_ACCESS}.
  - Requester index constants REQ_C0_D, REQ_C0_I, REQ_C1_D, REQ_C1_I.
- Sub-module mem_arb_pick (combinational):
  - Inputs: active mask, exclude mask, last_core.
  - Outputs: one-hot winner, valid.

## Test plan
- Reset, then core0 icache reads 0x100 with RAM ACCESS after 2 BUSY cycles -> grant=0010 at cycle 1; req_wait[1]=1 for 2 cycles, 0 in cycle 3; req_load = ramload.
- Core0 icache and core1 dcache request at the same time -> grant=0100 first (dcache class); icache granted in the cycle after done, with no idle cycle.
- Both dcaches request continuously with no hold -> grants alternate 0001, 0100, 0001, and so on.
- Core1 dcache holds req_hold=1 for 3 accesses with MAX_HOLD=2 and core0 dcache pending -> core1 gets 2 accesses, then core0 is granted.
- Owner drops ren mid-BUSY -> next edge: state ARB_IDLE, ramREN=0, grant=0, last_core unchanged.
- RST asserted during ARB_ACCESS -> next edge: grant=0, RAM outputs 0; then simultaneous dcache requests -> core0 wins.
